// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the ID/EX operand stage.
//   alu_op_e      ALU operation encodings driven on Operation
//   fwd_sel_e     operand source chosen by the forwarding unit
//   id_ex_t       packed contents of the ID/EX pipeline register
//   ID_EX_BUBBLE  all-zero register image (no valid instruction, no side effects)
// The PIPE_* widths below set the register layout. Any module parameter that
// sizes a port feeding this register must keep the matching value.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_OP_W   = 4;
  localparam int PIPE_REG_W  = 5;

  typedef enum logic [PIPE_OP_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_XOR = 4'b0010,
    ALU_ADD = 4'b0100,
    ALU_SUB = 4'b0101,
    ALU_EQ  = 4'b1000,
    ALU_SLL = 4'b1100,
    ALU_SRL = 4'b1101,
    ALU_SRA = 4'b1110
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                   valid;
    logic [PIPE_REG_W-1:0]  rs1;
    logic [PIPE_REG_W-1:0]  rs2;
    logic [PIPE_REG_W-1:0]  rd;
    logic [PIPE_DATA_W-1:0] rs1_data;
    logic [PIPE_DATA_W-1:0] rs2_data;
    logic [PIPE_DATA_W-1:0] imm;
    logic                   alu_src;
    alu_op_e                alu_op;
    logic                   reg_write;
    logic                   mem_read;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_operand_stage_fwd_unit.sv
// fwd_unit: chooses the source of each EX operand from the registers in
// flight further down the pipe.
// Ports:
//   ex_rs1, ex_rs2   source indices of the instruction currently in EX
//   mem_rd, mem_reg_write   EX/MEM destination and its write enable
//   wb_rd, wb_reg_write     MEM/WB destination and its write enable
//   fwd_a_sel, fwd_b_sel    operand source for rs1 / rs2
// EX/MEM holds the younger result, so it beats MEM/WB. x0 is hard-wired to
// zero, so a write to it must never be forwarded.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = PIPE_REG_W
) (
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output fwd_sel_e              fwd_a_sel,
  output fwd_sel_e              fwd_b_sel
);

  logic mem_live;
  logic wb_live;

  assign mem_live = mem_reg_write && (mem_rd != '0);
  assign wb_live  = wb_reg_write && (wb_rd != '0);

  always_comb begin
    fwd_a_sel = FWD_REG;
    fwd_b_sel = FWD_REG;
    if (mem_live && (mem_rd == ex_rs1)) begin
      fwd_a_sel = FWD_MEM;
    end else if (wb_live && (wb_rd == ex_rs1)) begin
      fwd_a_sel = FWD_WB;
    end
    if (mem_live && (mem_rd == ex_rs2)) begin
      fwd_b_sel = FWD_MEM;
    end else if (wb_live && (wb_rd == ex_rs2)) begin
      fwd_b_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with operand forwarding and
// load-use hazard detection, feeding SrcA/SrcB/Operation to the ALU.
// Configuration macro: EX_FWD_EN
//   defined   - EX/MEM and MEM/WB forwarding plus load-use bubble insertion
//   undefined - operands come straight from the registered file data and
//               hazard_stall is tied low (software must schedule NOPs)
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall, flush      hold the stage / load a bubble
//   id_*              decoded instruction from the decode stage
//   mem_*, wb_*       destinations and results of the two later stages
//   SrcA, SrcB        ALU operands (signed), Operation the ALU op code
//   ex_store_data     forwarded rs2 value for stores
//   ex_rd, ex_reg_write, ex_mem_read, ex_valid   registered stage control
//   hazard_stall      freeze IF/ID while a load-use bubble is inserted
// Register update priority: reset > flush > stall > load-use bubble > capture.
module id_ex_operand_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH    = PIPE_DATA_W,
  parameter int OPCODE_LENGTH = PIPE_OP_W,
  parameter int REG_ADDR_W    = PIPE_REG_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         id_valid,
  input  logic [REG_ADDR_W-1:0]        id_rs1,
  input  logic [REG_ADDR_W-1:0]        id_rs2,
  input  logic [REG_ADDR_W-1:0]        id_rd,
  input  logic [DATA_WIDTH-1:0]        id_rs1_data,
  input  logic [DATA_WIDTH-1:0]        id_rs2_data,
  input  logic [DATA_WIDTH-1:0]        id_imm,
  input  logic                         id_alu_src,
  input  logic                         id_uses_rs2,
  input  logic [OPCODE_LENGTH-1:0]     id_alu_op,
  input  logic                         id_reg_write,
  input  logic                         id_mem_read,
  input  logic [REG_ADDR_W-1:0]        mem_rd,
  input  logic                         mem_reg_write,
  input  logic [DATA_WIDTH-1:0]        mem_result,
  input  logic [REG_ADDR_W-1:0]        wb_rd,
  input  logic                         wb_reg_write,
  input  logic [DATA_WIDTH-1:0]        wb_result,
  output logic signed [DATA_WIDTH-1:0] SrcA,
  output logic signed [DATA_WIDTH-1:0] SrcB,
  output logic [OPCODE_LENGTH-1:0]     Operation,
  output logic [DATA_WIDTH-1:0]        ex_store_data,
  output logic [REG_ADDR_W-1:0]        ex_rd,
  output logic                         ex_reg_write,
  output logic                         ex_mem_read,
  output logic                         ex_valid,
  output logic                         hazard_stall
);

  id_ex_t                ex_q;
  id_ex_t                ex_d;
  id_ex_t                id_capture;
  logic                  load_use;
  logic [DATA_WIDTH-1:0] rs1_fwd;
  logic [DATA_WIDTH-1:0] rs2_fwd;

`ifdef EX_FWD_EN
  fwd_sel_e fwd_a_sel;
  fwd_sel_e fwd_b_sel;

  // A load in EX has no data until MEM, so a consumer in ID must wait one cycle.
  always_comb begin
    load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
               ((ex_q.rd == id_rs1) || (id_uses_rs2 && (ex_q.rd == id_rs2)));
  end

  assign hazard_stall = load_use && !reset;

  fwd_unit #(
    .REG_ADDR_W    (REG_ADDR_W)
  ) u_fwd_unit (
    .ex_rs1        (ex_q.rs1),
    .ex_rs2        (ex_q.rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel)
  );

  always_comb begin
    case (fwd_a_sel)
      FWD_MEM: rs1_fwd = mem_result;
      FWD_WB:  rs1_fwd = wb_result;
      default: rs1_fwd = ex_q.rs1_data;
    endcase
    case (fwd_b_sel)
      FWD_MEM: rs2_fwd = mem_result;
      FWD_WB:  rs2_fwd = wb_result;
      default: rs2_fwd = ex_q.rs2_data;
    endcase
  end
`else
  // Without forwarding the later-stage buses and registered indices are not
  // consumed; they are reduced here only so the ports stay in the interface.
  logic unused_fwd_inputs;

  assign unused_fwd_inputs = ^{mem_rd, mem_reg_write, mem_result, wb_rd,
                               wb_reg_write, wb_result, id_uses_rs2,
                               ex_q.rs1, ex_q.rs2};
  assign load_use     = 1'b0;
  assign hazard_stall = 1'b0;
  assign rs1_fwd      = ex_q.rs1_data;
  assign rs2_fwd      = ex_q.rs2_data;
`endif

  // An empty decode slot is captured as a bubble so it carries no side effects.
  always_comb begin
    id_capture = ID_EX_BUBBLE;
    if (id_valid) begin
      id_capture.valid     = 1'b1;
      id_capture.rs1       = id_rs1;
      id_capture.rs2       = id_rs2;
      id_capture.rd        = id_rd;
      id_capture.rs1_data  = id_rs1_data;
      id_capture.rs2_data  = id_rs2_data;
      id_capture.imm       = id_imm;
      id_capture.alu_src   = id_alu_src;
      id_capture.alu_op    = alu_op_e'(id_alu_op);
      id_capture.reg_write = id_reg_write;
      id_capture.mem_read  = id_mem_read;
    end
  end

  // Stall holding beats the load-use bubble, so a held load keeps
  // hazard_stall high and the bubble goes in once the hold is released.
  always_comb begin
    ex_d = id_capture;
    if (flush) begin
      ex_d = ID_EX_BUBBLE;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = ID_EX_BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= ID_EX_BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign SrcA          = rs1_fwd;
  assign SrcB          = ex_q.alu_src ? ex_q.imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign Operation     = ex_q.alu_op;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_valid      = ex_q.valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: scoreboard bench for id_ex_operand_stage.
// Expected stage outputs are pushed when stimulus is driven and popped after
// the clock edge. Expectations follow EX_FWD_EN the same way the design does.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        id_valid, id_alu_src, id_uses_rs2, id_reg_write, id_mem_read;
  logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, mem_result, wb_result;
  logic [3:0]  id_alu_op;
  logic        mem_reg_write, wb_reg_write;
  logic signed [31:0] SrcA, SrcB;
  logic [3:0]  Operation;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_valid, hazard_stall;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .id_rs1_data   (id_rs1_data),
    .id_rs2_data   (id_rs2_data),
    .id_imm        (id_imm),
    .id_alu_src    (id_alu_src),
    .id_uses_rs2   (id_uses_rs2),
    .id_alu_op     (id_alu_op),
    .id_reg_write  (id_reg_write),
    .id_mem_read   (id_mem_read),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .SrcA          (SrcA),
    .SrcB          (SrcB),
    .Operation     (Operation),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_valid      (ex_valid),
    .hazard_stall  (hazard_stall)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        aluSrc;
    logic [3:0]  op;
    logic        rw, mr;
  } mstate_t;

  typedef struct {
    logic [31:0] srcA, srcB, store;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        valid, rw, mr;
  } expect_t;

  mstate_t model;
  mstate_t bubbleState;
  expect_t scoreQ[$];
  int      checks = 0;
  int      errors = 0;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Operand value the EX stage should see for a source register.
  function automatic logic [31:0] fwdVal(input logic [4:0] rs, input logic [31:0] raw);
`ifdef EX_FWD_EN
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs) return mem_result;
    if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) return wb_result;
`endif
    return raw;
  endfunction

  // Load in EX whose result a decode-stage instruction needs right now.
  function automatic logic modelHazard();
`ifdef EX_FWD_EN
    return !reset && model.valid && model.mr && model.rd != 5'd0 && id_valid &&
           (model.rd == id_rs1 || (id_uses_rs2 && model.rd == id_rs2));
`else
    return 1'b0;
`endif
  endfunction

  task automatic setInstr(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rdd, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic asrc, input logic u2,
                          input logic [3:0] op, input logic rw, input logic mr);
    id_valid = v;     id_rs1 = r1;       id_rs2 = r2;       id_rd = rdd;
    id_rs1_data = a;  id_rs2_data = b;   id_imm = im;       id_alu_src = asrc;
    id_uses_rs2 = u2; id_alu_op = op;    id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic setFwd(input logic [4:0] mrd, input logic mrw, input logic [31:0] mres,
                        input logic [4:0] wrd, input logic wrw, input logic [31:0] wres);
    mem_rd = mrd; mem_reg_write = mrw; mem_result = mres;
    wb_rd = wrd;  wb_reg_write = wrw;  wb_result = wres;
  endtask

  // One clock: check hazard_stall, predict the next register image, clock,
  // then compare every stage output. Called and returns at a falling edge.
  task automatic applyStimulus(input logic rst, input logic stl, input logic fl);
    mstate_t nxt;
    expect_t e;
    logic    hz;
    reset = rst; stall = stl; flush = fl;
    #1;
    hz = modelHazard();
    checkOutput("hazard_stall", {31'd0, hazard_stall}, {31'd0, hz});
    if (rst || fl) nxt = bubbleState;
    else if (stl) nxt = model;
    else if (hz || !id_valid) nxt = bubbleState;
    else nxt = '{1'b1, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
                 id_alu_src, id_alu_op, id_reg_write, id_mem_read};
    e.srcA  = fwdVal(nxt.rs1, nxt.d1);
    e.store = fwdVal(nxt.rs2, nxt.d2);
    e.srcB  = nxt.aluSrc ? nxt.imm : e.store;
    e.op    = nxt.op;
    e.rd    = nxt.rd;
    e.valid = nxt.valid;
    e.rw    = nxt.rw;
    e.mr    = nxt.mr;
    scoreQ.push_back(e);
    @(posedge clk);
    model = nxt;
    #1;
    e = scoreQ.pop_front();
    checkOutput("SrcA", SrcA, e.srcA);
    checkOutput("SrcB", SrcB, e.srcB);
    checkOutput("ex_store_data", ex_store_data, e.store);
    checkOutput("Operation", {28'd0, Operation}, {28'd0, e.op});
    checkOutput("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
    checkOutput("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
    checkOutput("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, e.rw});
    checkOutput("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, e.mr});
    @(negedge clk);
  endtask

  // Combinational operand check after changing only the forwarding buses.
  task automatic checkForward(input string tag);
    logic [31:0] b;
    #1;
    b = fwdVal(model.rs2, model.d2);
    checkOutput({tag, "_SrcA"}, SrcA, fwdVal(model.rs1, model.d1));
    checkOutput({tag, "_SrcB"}, SrcB, model.aluSrc ? model.imm : b);
    checkOutput({tag, "_store"}, ex_store_data, b);
  endtask

  initial begin
    bubbleState = '{1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    model = bubbleState;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    setFwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    setInstr(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b0);
    @(negedge clk);

    // Reset held two cycles with a valid instruction waiting in decode.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);

    // ADD x3,x1,x2.
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Consumer of x3 with both later stages writing x3: EX/MEM wins.
    setInstr(1'b1, 5'd3, 5'd1, 5'd5, 32'h55, 32'h66, 32'd0, 1'b0, 1'b1, 4'b0101, 1'b1, 1'b0);
    setFwd(5'd3, 1'b1, 32'd12, 5'd3, 1'b1, 32'd99);
    applyStimulus(1'b0, 1'b0, 1'b0);
    mem_reg_write = 1'b0;
    checkForward("fwd_wb");
    mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1'b1;
    checkForward("fwd_x0");

    // rs2 forwarding into SrcB and store data, then an immediate operand.
    setInstr(1'b1, 5'd2, 5'd6, 5'd7, 32'h11, 32'h22, 32'h1234, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    setFwd(5'd9, 1'b1, 32'hAAAA, 5'd6, 1'b1, 32'hBBBB);
    applyStimulus(1'b0, 1'b0, 1'b0);
    setInstr(1'b1, 5'd6, 5'd6, 5'd7, 32'h11, 32'h22, 32'hFFFF_FFF0, 1'b1, 1'b1, 4'b1110, 1'b1, 1'b0);
    setFwd(5'd6, 1'b1, 32'h8000_0001, 5'd6, 1'b1, 32'hBBBB);
    applyStimulus(1'b0, 1'b0, 1'b0);
    setFwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);

    // LW x4 then a dependent op: one bubble, then capture.
    setInstr(1'b1, 5'd1, 5'd0, 5'd4, 32'h100, 32'd0, 32'd8, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    setInstr(1'b1, 5'd4, 5'd2, 5'd8, 32'h44, 32'h45, 32'd0, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Load x6: rs2 match only counts when the instruction reads rs2.
    setInstr(1'b1, 5'd1, 5'd0, 5'd6, 32'h200, 32'd0, 32'd4, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    setInstr(1'b1, 5'd1, 5'd6, 5'd9, 32'h1, 32'h2, 32'd3, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    setInstr(1'b1, 5'd1, 5'd0, 5'd6, 32'h200, 32'd0, 32'd4, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    setInstr(1'b1, 5'd1, 5'd6, 5'd9, 32'h1, 32'h2, 32'd3, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Load to x0 never stalls a reader of x0.
    setInstr(1'b1, 5'd1, 5'd0, 5'd0, 32'h300, 32'd0, 32'd0, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    setInstr(1'b1, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'd1, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // External stall for three cycles with changing decode inputs.
    for (int i = 0; i < 3; i++) begin
      setInstr(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(1, 31)),
               $urandom, $urandom, $urandom, 1'($urandom), 1'b1, 4'($urandom), 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
    end

    // Stall with a load-use pending: hold wins, then flush beats stall.
    setInstr(1'b1, 5'd2, 5'd0, 5'd11, 32'h400, 32'd0, 32'd0, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    setInstr(1'b1, 5'd11, 5'd3, 5'd12, 32'h5, 32'h6, 32'd0, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);

    // Empty decode slot becomes a bubble; reset mid-stream clears the stage.
    setInstr(1'b1, 5'd1, 5'd2, 5'd13, 32'h7, 32'h8, 32'd0, 1'b0, 1'b1, 4'b1100, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    id_valid = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    id_valid = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Random traffic over a small register range to provoke hits.
    for (int i = 0; i < 80; i++) begin
      setInstr(($urandom_range(0, 4) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'($urandom),
               1'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
      setFwd(5'($urandom_range(0, 7)), 1'($urandom), $urandom,
             5'($urandom_range(0, 7)), 1'($urandom), $urandom);
      applyStimulus(($urandom_range(0, 24) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
